banked_register_file: RTL and testbench

- Parametrised general-purpose register file for the CPU datapath, successor to the fixed 16x32, two-read-port file.
- Provides N registered read ports, one byte-enabled write port, same-cycle write-to-read forwarding and PC-index read override.
- Adds a PC-write redirect output and a per-register pending-write scoreboard so decode can detect RAW hazards.
- Sits between decode (read addresses, claims) and writeback (write port).

---
 rtl/banked_register_file_if.sv | 33 +++
 rtl/banked_register_file.sv | 94 +++++++++
 tb/tb_banked_register_file.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banked_register_file_if.sv
// Decode/writeback bus of the banked register file: read ports, write port,
// scoreboard claim and PC redirect.
interface banked_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic                     hold_i;
    logic [DATA_W-1:0]        pc_i;
    logic                     wr_en_i;
    logic [ADDR_W-1:0]        wr_addr_i;
    logic [DATA_W/8-1:0]      wr_be_i;
    logic [DATA_W-1:0]        wr_data_i;
    logic                     claim_en_i;
    logic [ADDR_W-1:0]        claim_addr_i;
    logic                     pc_wr_o;
    logic [DATA_W-1:0]        pc_wr_data_o;

    modport master (
        output rd_addr_i, hold_i, pc_i, wr_en_i, wr_addr_i, wr_be_i, wr_data_i,
               claim_en_i, claim_addr_i,
        input  rd_data_o, rd_busy_o, pc_wr_o, pc_wr_data_o
    );

    modport slave (
        input  rd_addr_i, hold_i, pc_i, wr_en_i, wr_addr_i, wr_be_i, wr_data_i,
               claim_en_i, claim_addr_i,
        output rd_data_o, rd_busy_o, pc_wr_o, pc_wr_data_o
    );
endinterface

// File: rtl/banked_register_file.sv
// Parametrised register file: N registered read ports, byte-enabled write with
// optional bypass, PC-index aliasing/redirect and a pending-write scoreboard.
module banked_register_file #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_RD    = 2,
    parameter int PC_INDEX  = 15,
    parameter int PC_OFFSET = 8,
    parameter int FORWARD   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    banked_register_file_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;
    localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_INDEX);
    localparam logic [DATA_W-1:0] PC_OFF = DATA_W'(PC_OFFSET);

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [DEPTH-1:0]         r_busy;
    logic [NUM_RD*DATA_W-1:0] r_rd_data;
    logic [NUM_RD-1:0]        r_rd_busy;
    logic                     r_pc_wr;
    logic [DATA_W-1:0]        r_pc_wr_data;

    logic [DEPTH-1:0]         w_busy_next;
    logic [DATA_W-1:0]        w_merged;
    logic [NUM_RD*DATA_W-1:0] w_rd_val;
    logic [NUM_RD-1:0]        w_rd_busy;
    logic                     w_wr_pc;

    assign w_wr_pc = bus.wr_en_i && (bus.wr_addr_i == PC_A);

    always_comb begin
        w_merged = r_mem[bus.wr_addr_i];
        for (int unsigned b = 0; b < NB; b++) begin
            if (bus.wr_be_i[b]) w_merged[b*8 +: 8] = bus.wr_data_i[b*8 +: 8];
        end
    end

    // Clear before set so a same-cycle claim wins over the write's release.
    always_comb begin
        w_busy_next = r_busy;
        if (bus.wr_en_i)    w_busy_next[bus.wr_addr_i]    = 1'b0;
        if (bus.claim_en_i) w_busy_next[bus.claim_addr_i] = 1'b1;
        w_busy_next[PC_A] = 1'b0;
    end

    always_comb begin
        w_rd_val  = '0;
        w_rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            w_rd_busy[k] = w_busy_next[bus.rd_addr_i[k*ADDR_W +: ADDR_W]];
            if (bus.rd_addr_i[k*ADDR_W +: ADDR_W] == PC_A)
                w_rd_val[k*DATA_W +: DATA_W] = bus.pc_i + PC_OFF;
            else if (FORWARD != 0 && bus.wr_en_i &&
                     bus.wr_addr_i == bus.rd_addr_i[k*ADDR_W +: ADDR_W])
                w_rd_val[k*DATA_W +: DATA_W] = w_merged;
            else
                w_rd_val[k*DATA_W +: DATA_W] = r_mem[bus.rd_addr_i[k*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_busy       <= '0;
            r_rd_data    <= '0;
            r_rd_busy    <= '0;
            r_pc_wr      <= 1'b0;
            r_pc_wr_data <= '0;
        end else begin
            r_busy  <= w_busy_next;
            r_pc_wr <= w_wr_pc;
            if (w_wr_pc) r_pc_wr_data <= bus.wr_data_i;
            if (bus.wr_en_i && !w_wr_pc) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (bus.wr_be_i[b])
                        r_mem[bus.wr_addr_i][b*8 +: 8] <= bus.wr_data_i[b*8 +: 8];
                end
            end
            if (!bus.hold_i) begin
                r_rd_data <= w_rd_val;
                r_rd_busy <= w_rd_busy;
            end
        end
    end

    assign bus.rd_data_o    = r_rd_data;
    assign bus.rd_busy_o    = r_rd_busy;
    assign bus.pc_wr_o      = r_pc_wr;
    assign bus.pc_wr_data_o = r_pc_wr_data;
endmodule

// File: tb/tb_banked_register_file.sv
// Bench for banked_register_file: directed scenarios plus randomized traffic
// against an array-based reference model, with bypassing and non-bypassing instances.
module tb_banked_register_file;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int NR  = 2;
    localparam int PCI = 15;
    localparam int PCO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] t_rd_addr [NR];
    logic          t_hold;
    logic [DW-1:0] t_pc;
    logic          t_wr_en;
    logic [AW-1:0] t_wr_addr;
    logic [3:0]    t_wr_be;
    logic [DW-1:0] t_wr_data;
    logic          t_claim_en;
    logic [AW-1:0] t_claim_addr;

    banked_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();
    banked_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_nf ();

    assign bus.rd_addr_i    = {t_rd_addr[1], t_rd_addr[0]};
    assign bus.hold_i       = t_hold;
    assign bus.pc_i         = t_pc;
    assign bus.wr_en_i      = t_wr_en;
    assign bus.wr_addr_i    = t_wr_addr;
    assign bus.wr_be_i      = t_wr_be;
    assign bus.wr_data_i    = t_wr_data;
    assign bus.claim_en_i   = t_claim_en;
    assign bus.claim_addr_i = t_claim_addr;
    assign bus_nf.rd_addr_i    = {t_rd_addr[1], t_rd_addr[0]};
    assign bus_nf.hold_i       = t_hold;
    assign bus_nf.pc_i         = t_pc;
    assign bus_nf.wr_en_i      = t_wr_en;
    assign bus_nf.wr_addr_i    = t_wr_addr;
    assign bus_nf.wr_be_i      = t_wr_be;
    assign bus_nf.wr_data_i    = t_wr_data;
    assign bus_nf.claim_en_i   = t_claim_en;
    assign bus_nf.claim_addr_i = t_claim_addr;

    banked_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PC_INDEX(PCI),
                           .PC_OFFSET(PCO), .FORWARD(1)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus.slave));
    banked_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PC_INDEX(PCI),
                           .PC_OFFSET(PCO), .FORWARD(0)) dut_nf (
        .clk_i(clk), .rst_i(rst), .bus(bus_nf.slave));

    // Reference model state and expected outputs
    logic [DW-1:0] m_mem [16];
    bit            m_busy [16];
    logic [DW-1:0] exp_rd [NR];
    logic [DW-1:0] exp_rd_nf [NR];
    logic          exp_busy [NR];
    logic          exp_pc_wr;
    logic [DW-1:0] exp_pc_data;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        for (int k = 0; k < NR; k++) begin
            exp_rd[k] = '0; exp_rd_nf[k] = '0; exp_busy[k] = 1'b0;
        end
        exp_pc_wr   = 1'b0;
        exp_pc_data = '0;
    endtask

    task automatic idle();
        t_hold = 1'b0; t_wr_en = 1'b0; t_wr_be = '0; t_claim_en = 1'b0;
    endtask

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic tick();
        logic [DW-1:0] mask;
        logic [DW-1:0] merged;
        bit            nb [16];
        logic [AW-1:0] a;
        mask = '0;
        for (int b = 0; b < 4; b++) if (t_wr_be[b]) mask = mask | (32'hFF << (8*b));
        merged = (t_wr_data & mask) | (m_mem[t_wr_addr] & ~mask);
        nb = m_busy;
        if (t_wr_en) nb[t_wr_addr] = 1'b0;
        if (t_claim_en && t_claim_addr != PCI) nb[t_claim_addr] = 1'b1;
        if (!t_hold) begin
            for (int k = 0; k < NR; k++) begin
                a = t_rd_addr[k];
                if (a == PCI) begin
                    exp_rd[k]    = t_pc + PCO;
                    exp_rd_nf[k] = t_pc + PCO;
                end else begin
                    exp_rd_nf[k] = m_mem[a];
                    exp_rd[k]    = (t_wr_en && t_wr_addr == a) ? merged : m_mem[a];
                end
                exp_busy[k] = nb[a];
            end
        end
        exp_pc_wr = t_wr_en && (t_wr_addr == PCI);
        if (exp_pc_wr) exp_pc_data = t_wr_data;
        if (t_wr_en && t_wr_addr != PCI) m_mem[t_wr_addr] = merged;
        m_busy = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        t_pc = '0; t_wr_addr = '0; t_wr_data = '0; t_claim_addr = '0;
        t_rd_addr[0] = '0; t_rd_addr[1] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (bus.rd_data_o[k*DW +: DW] !== 32'h0 || bus.rd_busy_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_rd%0d got %h/%b exp 0/0", k, bus.rd_data_o[k*DW +: DW], bus.rd_busy_o[k]);
            end
        end
        checks++;
        if (bus.pc_wr_o !== 1'b0 || bus.pc_wr_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got %b/%h exp 0/0", bus.pc_wr_o, bus.pc_wr_data_o);
        end
        rst = 1'b0;
        t_rd_addr[0] = 4'd3; t_rd_addr[1] = 4'd15; t_pc = 32'h100;
        tick();
        checks++;
        if (bus.rd_data_o[31:0] !== 32'h0) begin
            errors++; $display("FAIL read_r3 got %h exp 0", bus.rd_data_o[31:0]);
        end
        checks++;
        if (bus.rd_data_o[63:32] !== 32'h108) begin
            errors++; $display("FAIL read_pc got %h exp 108", bus.rd_data_o[63:32]);
        end
    endtask

    task automatic test_byte_write();
        t_wr_en = 1'b1; t_wr_addr = 4'd4; t_wr_be = 4'hF; t_wr_data = 32'hDEADBEEF;
        tick();
        t_wr_be = 4'h1; t_wr_data = 32'h11;
        tick();
        idle();
        t_rd_addr[0] = 4'd4; t_rd_addr[1] = 4'd4;
        tick();
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (bus.rd_data_o[k*DW +: DW] !== 32'hDEADBE11) begin
                errors++; $display("FAIL byte_write%0d got %h exp deadbe11", k, bus.rd_data_o[k*DW +: DW]);
            end
        end
    endtask

    task automatic test_forward();
        t_wr_en = 1'b1; t_wr_addr = 4'd5; t_wr_be = 4'hF; t_wr_data = 32'h12345678;
        tick();
        t_wr_be = 4'hC; t_wr_data = 32'hA5A5A5A5;
        t_rd_addr[0] = 4'd5; t_rd_addr[1] = 4'd5;
        tick();
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (bus.rd_data_o[k*DW +: DW] !== 32'hA5A55678) begin
                errors++; $display("FAIL fwd%0d got %h exp a5a55678", k, bus.rd_data_o[k*DW +: DW]);
            end
            checks++;
            if (bus_nf.rd_data_o[k*DW +: DW] !== 32'h12345678) begin
                errors++; $display("FAIL nofwd%0d got %h exp 12345678", k, bus_nf.rd_data_o[k*DW +: DW]);
            end
        end
        idle();
        tick();
        checks++;
        if (bus_nf.rd_data_o[31:0] !== 32'hA5A55678) begin
            errors++; $display("FAIL nofwd_after got %h exp a5a55678", bus_nf.rd_data_o[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        t_claim_en = 1'b1; t_claim_addr = 4'd6;
        t_rd_addr[0] = 4'd6; t_rd_addr[1] = 4'd15;
        tick();
        checks++;
        if (bus.rd_busy_o !== 2'b01) begin
            errors++; $display("FAIL claim_busy got %b exp 01", bus.rd_busy_o);
        end
        t_wr_en = 1'b1; t_wr_addr = 4'd6; t_wr_be = 4'hF; t_wr_data = 32'h66;
        t_claim_addr = 4'd6;
        tick();
        checks++;
        if (bus.rd_busy_o[0] !== 1'b1) begin
            errors++; $display("FAIL claim_wins got %b exp 1", bus.rd_busy_o[0]);
        end
        t_claim_addr = 4'd15; t_wr_be = 4'h0;
        tick();
        checks++;
        if (bus.rd_busy_o !== 2'b00) begin
            errors++; $display("FAIL write_clear got %b exp 00", bus.rd_busy_o);
        end
        checks++;
        if (bus.rd_data_o[31:0] !== 32'h66) begin
            errors++; $display("FAIL be0_nowrite got %h exp 66", bus.rd_data_o[31:0]);
        end
        idle();
    endtask

    task automatic test_pc_write();
        t_wr_en = 1'b1; t_wr_addr = 4'd15; t_wr_be = 4'h0; t_wr_data = 32'h2000;
        tick();
        checks++;
        if (bus.pc_wr_o !== 1'b1 || bus.pc_wr_data_o !== 32'h2000) begin
            errors++; $display("FAIL pc_wr got %b/%h exp 1/2000", bus.pc_wr_o, bus.pc_wr_data_o);
        end
        idle();
        t_rd_addr[0] = 4'd15; t_pc = 32'h40;
        tick();
        checks++;
        if (bus.pc_wr_o !== 1'b0 || bus.pc_wr_data_o !== 32'h2000) begin
            errors++; $display("FAIL pc_wr_end got %b/%h exp 0/2000", bus.pc_wr_o, bus.pc_wr_data_o);
        end
        checks++;
        if (bus.rd_data_o[31:0] !== 32'h48) begin
            errors++; $display("FAIL pc_read got %h exp 48", bus.rd_data_o[31:0]);
        end
    endtask

    task automatic test_hold();
        t_rd_addr[0] = 4'd7; t_rd_addr[1] = 4'd7;
        tick();
        t_hold = 1'b1; t_wr_en = 1'b1; t_wr_addr = 4'd7; t_wr_be = 4'hF; t_wr_data = 32'h77;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.rd_data_o[31:0] !== 32'h0) begin
                errors++; $display("FAIL hold_frozen cyc %0d got %h exp 0", c, bus.rd_data_o[31:0]);
            end
        end
        idle();
        tick();
        checks++;
        if (bus.rd_data_o[31:0] !== 32'h77) begin
            errors++; $display("FAIL hold_release got %h exp 77", bus.rd_data_o[31:0]);
        end
        t_hold = 1'b1; t_claim_en = 1'b1; t_claim_addr = 4'd7;
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.rd_data_o !== 64'h0 || bus.rd_busy_o !== 2'b00 || bus.pc_wr_o !== 1'b0 ||
            bus.pc_wr_data_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got %h/%b/%b/%h exp all 0", bus.rd_data_o, bus.rd_busy_o,
                     bus.pc_wr_o, bus.pc_wr_data_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        tick();
        checks++;
        if (bus.rd_data_o[31:0] !== 32'h0 || bus.rd_busy_o[0] !== 1'b0) begin
            errors++; $display("FAIL post_reset_r7 got %h/%b exp 0/0", bus.rd_data_o[31:0], bus.rd_busy_o[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            t_rd_addr[0] = 4'($urandom_range(0, 15));
            t_rd_addr[1] = ($urandom_range(0, 3) == 0) ? t_rd_addr[0] : 4'($urandom_range(0, 15));
            t_hold       = ($urandom_range(0, 7) == 0);
            t_pc         = $urandom;
            t_wr_en      = ($urandom_range(0, 1) == 1);
            t_wr_addr    = 4'($urandom_range(0, 15));
            t_wr_be      = 4'($urandom);
            t_wr_data    = $urandom;
            t_claim_en   = ($urandom_range(0, 2) == 0);
            t_claim_addr = ($urandom_range(0, 3) == 0) ? t_wr_addr : 4'($urandom_range(0, 15));
            tick();
            for (int k = 0; k < NR; k++) begin
                checks++;
                if (bus.rd_data_o[k*DW +: DW] !== exp_rd[k] || bus.rd_busy_o[k] !== exp_busy[k]) begin
                    errors++;
                    $display("FAIL rand_rd%0d cyc %0d got %h/%b exp %h/%b", k, c,
                             bus.rd_data_o[k*DW +: DW], bus.rd_busy_o[k], exp_rd[k], exp_busy[k]);
                end
                checks++;
                if (bus_nf.rd_data_o[k*DW +: DW] !== exp_rd_nf[k] || bus_nf.rd_busy_o[k] !== exp_busy[k]) begin
                    errors++;
                    $display("FAIL rand_nf%0d cyc %0d got %h/%b exp %h/%b", k, c,
                             bus_nf.rd_data_o[k*DW +: DW], bus_nf.rd_busy_o[k], exp_rd_nf[k], exp_busy[k]);
                end
            end
            checks++;
            if (bus.pc_wr_o !== exp_pc_wr || bus.pc_wr_data_o !== exp_pc_data) begin
                errors++;
                $display("FAIL rand_pc cyc %0d got %b/%h exp %b/%h", c, bus.pc_wr_o,
                         bus.pc_wr_data_o, exp_pc_wr, exp_pc_data);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_forward();
        test_scoreboard();
        test_pc_write();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
